// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding, digit limits and BCD helper
//
// Purpose:
//   Common definitions for the stopwatch controller slice: the 2-bit FSM
//   state encoding, the per-digit maximum values and a BCD increment helper
//   used by every digit counter.
// Ports:
//   none (package)

package stopwatch_pkg;

  // FSM state encoding (2 bits)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_PAUSE  = 2'd2;
  localparam logic [1:0] ST_ADJUST = 2'd3;

  // Largest legal value of a ones digit and of a tens digit in MM:SS
  localparam logic [3:0] DIGIT_MAX_ONES = 4'd9;
  localparam logic [3:0] DIGIT_MAX_TENS = 4'd5;

  // Next value of a wrapping BCD digit whose top value is max_val
  function automatic logic [3:0] bcd_next(input logic [3:0] value,
                                          input logic [3:0] max_val);
    return (value == max_val) ? 4'd0 : value + 4'd1;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// rtl/bcd_digit_counter.sv - single wrapping BCD digit with carry out
//
// Purpose:
//   One decimal digit that counts 0..MAX and wraps to 0. The carry output is
//   combinational so a chain of these digits ripples within one clock edge.
// Ports:
//   src_clk  in   1  clock, rising edge
//   src_rst  in   1  asynchronous active-high reset, value -> 0
//   clr      in   1  synchronous clear, value -> 0 (wins over inc)
//   inc      in   1  advance by one this cycle
//   value    out  4  registered digit value, 0..MAX
//   carry    out  1  inc & (value == MAX): this digit wraps on the next edge

module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter logic [3:0] MAX = DIGIT_MAX_ONES
) (
  input  logic       src_clk,
  input  logic       src_rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] value,
  output logic       carry
);

  assign carry = inc & (value == MAX);

  always_ff @(posedge src_clk or posedge src_rst) begin
    if (src_rst) begin
      value <= 4'd0;
    end else if (clr) begin
      value <= 4'd0;
    end else if (inc) begin
      value <= bcd_next(value, MAX);
    end
  end

endmodule

// File: rtl/stopwatch_controller.sv
// rtl/stopwatch_controller.sv - MM:SS stopwatch sequencer (FSM, prescaler, carry chain)
//
// Purpose:
//   Runs the IDLE/RUN/PAUSE/ADJUST state machine from the user controls,
//   divides src_clk down to the count tick, chains four BCD digits into
//   MM:SS and generates the ADJUST blink square wave. All outputs are
//   registered and feed the seven-segment mux directly.
// Parameters:
//   CLK_HZ    src_clk frequency in Hz
//   TICK_HZ   count rate; DIV = CLK_HZ/TICK_HZ (must be >= 2)
//   BLINK_HZ  blink toggle rate; BDIV = CLK_HZ/(2*BLINK_HZ)
// Ports:
//   src_clk     in   1  system clock
//   src_rst     in   1  asynchronous active-high reset
//   start_stop  in   1  pulse, toggles RUN/PAUSE (ignored in ADJUST)
//   clear       in   1  pulse, zero digits and go IDLE; beats everything
//   adj_en      in   1  level, request ADJUST from IDLE/PAUSE
//   adj_sel     in   1  0 = minutes field, 1 = seconds field
//   adj_step    in   1  pulse, +1 on the selected field in ADJUST
//   sec_ones    out  4  BCD 0..9
//   sec_tens    out  4  BCD 0..5
//   min_ones    out  4  BCD 0..9
//   min_tens    out  4  BCD 0..5
//   running     out  1  state == RUN
//   blink       out  1  BLINK_HZ square wave in ADJUST, else 0
//   rollover    out  1  one-cycle pulse on 59:59 -> 00:00 while running

module stopwatch_controller
  import stopwatch_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 1,
  parameter int BLINK_HZ = 2
) (
  input  logic       src_clk,
  input  logic       src_rst,
  input  logic       start_stop,
  input  logic       clear,
  input  logic       adj_en,
  input  logic       adj_sel,
  input  logic       adj_step,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic       running,
  output logic       blink,
  output logic       rollover
);

  localparam int DIV  = CLK_HZ / TICK_HZ;
  localparam int BDIV = CLK_HZ / (2 * BLINK_HZ);
  localparam int CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW   = (BDIV > 1) ? $clog2(BDIV) : 1;

  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [BW-1:0] BDIV_LAST = BW'(BDIV - 1);

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [BW-1:0] bcnt;

  logic run_entry;
  logic adj_entry;
  logic adj_stay;
  logic run_tick;
  logic adj_inc;

  logic sec_ones_inc;
  logic min_ones_inc;
  logic sec_ones_carry;
  logic sec_tens_carry;
  logic min_ones_carry;
  logic min_tens_carry;

  // Next-state logic. clear dominates; adj_en is checked before start_stop
  // so a simultaneous request lands in ADJUST rather than RUN.
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_PAUSE: begin
          if (adj_en) begin
            state_nxt = ST_ADJUST;
          end else if (start_stop) begin
            state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (start_stop) begin
            state_nxt = ST_PAUSE;
          end
        end
        ST_ADJUST: begin
          if (!adj_en) begin
            state_nxt = ST_PAUSE;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign run_entry = (state != ST_RUN) && (state_nxt == ST_RUN);
  assign adj_entry = (state != ST_ADJUST) && (state_nxt == ST_ADJUST);
  assign adj_stay  = (state == ST_ADJUST) && (state_nxt == ST_ADJUST);

  // The tick is decoded from the prescaler and acted on at the same edge
  // that wraps it, so digits show the new value one cycle after the tick.
  assign run_tick = (state == ST_RUN) && (cnt == DIV_LAST) && !clear;

  // A step is only honoured while ADJUST is still requested; a step in the
  // cycle adj_en drops would otherwise land as the state leaves ADJUST.
  assign adj_inc = (state == ST_ADJUST) && adj_en && adj_step && !clear;

  // Seconds and minutes are driven independently in ADJUST. The seconds to
  // minutes link is gated by run_tick, so a seconds wrap while adjusting
  // never disturbs the minutes field.
  assign sec_ones_inc = run_tick | (adj_inc & adj_sel);
  assign min_ones_inc = (run_tick & sec_tens_carry) | (adj_inc & ~adj_sel);

  bcd_digit_counter #(.MAX(DIGIT_MAX_ONES)) u_sec_ones (
    .src_clk (src_clk),
    .src_rst (src_rst),
    .clr     (clear),
    .inc     (sec_ones_inc),
    .value   (sec_ones),
    .carry   (sec_ones_carry)
  );

  bcd_digit_counter #(.MAX(DIGIT_MAX_TENS)) u_sec_tens (
    .src_clk (src_clk),
    .src_rst (src_rst),
    .clr     (clear),
    .inc     (sec_ones_carry),
    .value   (sec_tens),
    .carry   (sec_tens_carry)
  );

  bcd_digit_counter #(.MAX(DIGIT_MAX_ONES)) u_min_ones (
    .src_clk (src_clk),
    .src_rst (src_rst),
    .clr     (clear),
    .inc     (min_ones_inc),
    .value   (min_ones),
    .carry   (min_ones_carry)
  );

  bcd_digit_counter #(.MAX(DIGIT_MAX_TENS)) u_min_tens (
    .src_clk (src_clk),
    .src_rst (src_rst),
    .clr     (clear),
    .inc     (min_ones_carry),
    .value   (min_tens),
    .carry   (min_tens_carry)
  );

  always_ff @(posedge src_clk or posedge src_rst) begin
    if (src_rst) begin
      state   <= ST_IDLE;
      running <= 1'b0;
    end else begin
      state   <= state_nxt;
      running <= (state_nxt == ST_RUN);
    end
  end

  // Prescaler: restarts from 0 on every RUN entry so the first increment is
  // a full DIV cycles away; holds its value outside RUN.
  always_ff @(posedge src_clk or posedge src_rst) begin
    if (src_rst) begin
      cnt <= '0;
    end else if (clear || run_entry) begin
      cnt <= '0;
    end else if (state == ST_RUN) begin
      cnt <= (cnt == DIV_LAST) ? '0 : cnt + CW'(1);
    end
  end

  // Rollover can only come from the running chain: the minutes field wrapping
  // in ADJUST does not assert run_tick.
  always_ff @(posedge src_clk or posedge src_rst) begin
    if (src_rst) begin
      rollover <= 1'b0;
    end else begin
      rollover <= run_tick & min_tens_carry;
    end
  end

  // Blink divider: phase restarts on ADJUST entry and output drops to 0 on
  // the edge that leaves ADJUST.
  always_ff @(posedge src_clk or posedge src_rst) begin
    if (src_rst) begin
      bcnt  <= '0;
      blink <= 1'b0;
    end else if (adj_stay) begin
      if (bcnt == BDIV_LAST) begin
        bcnt  <= '0;
        blink <= ~blink;
      end else begin
        bcnt <= bcnt + BW'(1);
      end
    end else begin
      bcnt  <= '0;
      blink <= 1'b0;
    end
  end

  // adj_entry is implied by the else branch above (state was not ADJUST);
  // kept as a named term for readability of the FSM intent.
  logic unused_adj_entry;
  assign unused_adj_entry = adj_entry;

endmodule
